// File: rtl/dram_read_arbiter_pkg.sv
// dram_read_arbiter_pkg
// Shared types and constants for the two-requester DRAM burst read arbiter.
// The burst width lives here because the outstanding-burst tag record is
// a package type shared by the arbiter and its tag FIFO.
package dram_read_arbiter_pkg;

  localparam int unsigned MAXBURST_LOG = 4;
  localparam int unsigned MAXBURST_NUM = 1 << MAXBURST_LOG;
  localparam int unsigned BC_W         = MAXBURST_LOG + 1;

  // One record per issued burst: owner and beat count.
  typedef struct packed {
    logic            id;
    logic [BC_W-1:0] bc;
  } tag_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

endpackage

// File: rtl/dram_read_arbiter_if.sv
// dram_read_arbiter_if
// Avalon-MM burst read bundle.
//   master: drives address/read/burstcount, receives waitrequest/readdata/readdatavalid
//   slave : the opposite direction
interface dram_read_arbiter_if
  import dram_read_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 512
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic [BC_W-1:0]   burstcount;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/dram_tag_fifo.sv
// dram_tag_fifo
// In-order record of issued bursts. Show-ahead: head is the oldest entry.
// Ports: clock/resetn (async active-low), push + wr_tag, pop, head,
// empty, occupancy (0..2^DEPTH_LOG).
module dram_tag_fifo
  import dram_read_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               push,
  input  tag_t               wr_tag,
  input  logic               pop,
  output tag_t               head,
  output logic               empty,
  output logic [DEPTH_LOG:0] occupancy
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG;

  tag_t                 mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 full, do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (DEPTH_LOG+1)'(DEPTH));
  assign occupancy = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is still fine when the head leaves the same cycle.
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (DEPTH_LOG+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_tag;
  end

endmodule

// File: rtl/dram_read_arbiter.sv
// dram_read_arbiter
// Shares one Avalon-MM burst read master between two burst read requesters.
// Round-robin per burst command; an in-order tag FIFO routes each returned
// beat to the requester that issued its burst.
// Ports:
//   clock, resetn       : single clock, async active-low reset
//   rq0, rq1 (slave)    : requester command/response bundles
//   avm (master)        : DRAM read master bundle
//   avm_write/_writedata/_byteenable : write side, tied off
//   err_unexpected      : sticky, beat arrived with nothing outstanding
module dram_read_arbiter
  import dram_read_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 512,
  parameter int unsigned TAG_DEPTH_LOG = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  dram_read_arbiter_if.slave    rq0,
  dram_read_arbiter_if.slave    rq1,
  dram_read_arbiter_if.master   avm,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  err_unexpected
);
  localparam int unsigned TAG_DEPTH = 1 << TAG_DEPTH_LOG;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                rr_q, rr_d;          // 1: rq1 wins a tie
  logic                avm_read_q, avm_read_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BC_W-1:0]     bc_q, bc_d;
  logic [BC_W-1:0]     rem_q, rem_d;
  logic                active_q, active_d;  // rem_q holds the head's remaining beats
  logic                err_q, err_d;

  tag_t                head, push_tag;
  logic                empty, push, pop, accept, beat, tag_room;
  logic [BC_W-1:0]     cur_rem;
  logic [TAG_DEPTH_LOG:0] occupancy;

  assign tag_room = (occupancy < (TAG_DEPTH_LOG+1)'(TAG_DEPTH));
  assign accept   = (state_q == ISSUE) && !avm.waitrequest;
  assign push     = accept;
  assign push_tag = '{id: grant_q, bc: bc_q};
  assign beat     = avm.readdatavalid && !empty;

  // Command FSM
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    avm_read_d = avm_read_q;
    addr_d     = addr_q;
    bc_d       = bc_q;
    unique case (state_q)
      IDLE: begin
        if ((rq0.read || rq1.read) && tag_room) begin
          grant_d    = (rq0.read && rq1.read) ? rr_q : rq1.read;
          addr_d     = grant_d ? rq1.address    : rq0.address;
          bc_d       = grant_d ? rq1.burstcount : rq0.burstcount;
          avm_read_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!avm.waitrequest) begin
          avm_read_d = 1'b0;
          rr_d       = !grant_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response routing: the first beat of a burst loads the count from the head.
  always_comb begin
    cur_rem  = active_q ? rem_q : head.bc;
    rem_d    = rem_q;
    active_d = active_q;
    pop      = 1'b0;
    err_d    = err_q || (avm.readdatavalid && empty);
    if (beat) begin
      if (cur_rem == BC_W'(1)) begin
        pop      = 1'b1;
        active_d = 1'b0;
      end else begin
        rem_d    = cur_rem - BC_W'(1);
        active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      avm_read_q <= 1'b0;
      addr_q     <= '0;
      bc_q       <= '0;
      rem_q      <= '0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      avm_read_q <= avm_read_d;
      addr_q     <= addr_d;
      bc_q       <= bc_d;
      rem_q      <= rem_d;
      active_q   <= active_d;
      err_q      <= err_d;
    end
  end

  dram_tag_fifo #(
    .DEPTH_LOG (TAG_DEPTH_LOG)
  ) u_tag_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .wr_tag    (push_tag),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .occupancy (occupancy)
  );

  assign avm.address       = addr_q;
  assign avm.read          = avm_read_q;
  assign avm.burstcount    = bc_q;
  assign avm_write         = 1'b0;
  assign avm_writedata     = '0;
  assign avm_byteenable    = '1;
  assign err_unexpected    = err_q;

  assign rq0.waitrequest   = !(accept && !grant_q);
  assign rq1.waitrequest   = !(accept && grant_q);
  assign rq0.readdata      = avm.readdata;
  assign rq1.readdata      = avm.readdata;
  assign rq0.readdatavalid = beat && !head.id;
  assign rq1.readdatavalid = beat && head.id;

  a_rq0_bc_legal: assert property (@(posedge clock) disable iff (!resetn)
    rq0.read |-> (rq0.burstcount != '0 && rq0.burstcount <= BC_W'(MAXBURST_NUM)));
  a_rq1_bc_legal: assert property (@(posedge clock) disable iff (!resetn)
    rq1.read |-> (rq1.burstcount != '0 && rq1.burstcount <= BC_W'(MAXBURST_NUM)));

endmodule

// File: tb/tb_dram_read_arbiter.sv
// tb_dram_read_arbiter
// Self-checking bench: expected commands and beats are queued as stimulus
// is driven; a negedge monitor pops and compares them as the DUT responds.
module tb_dram_read_arbiter;
  import dram_read_arbiter_pkg::*;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          avm_write;
  logic [511:0]  avm_writedata;
  logic [63:0]   avm_byteenable;
  logic          err_unexpected;

  dram_read_arbiter_if #(.ADDR_W(32), .DATA_W(512)) rq0_if ();
  dram_read_arbiter_if #(.ADDR_W(32), .DATA_W(512)) rq1_if ();
  dram_read_arbiter_if #(.ADDR_W(32), .DATA_W(512)) avm_if ();

  dram_read_arbiter #(
    .ADDR_W        (32),
    .DATA_W        (512),
    .TAG_DEPTH_LOG (3)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .rq0            (rq0_if),
    .rq1            (rq1_if),
    .avm            (avm_if),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .err_unexpected (err_unexpected)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit              id;
    logic [31:0]     addr;
    logic [BC_W-1:0] bc;
  } cmd_t;

  typedef struct {
    bit           v0;
    bit           v1;
    logic [511:0] data;
  } beat_t;

  cmd_t        cmd_q[$];
  beat_t       beat_q[$];
  cmd_t        mon_c;
  beat_t       mon_b;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned accept_cnt = 0;

  task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // Drive a command and hold it until accepted, then drop read.
  task automatic rq_issue(input bit id, input logic [31:0] a, input logic [BC_W-1:0] bc);
    int unsigned n;
    n = 0;
    if (!id) begin
      rq0_if.read = 1'b1; rq0_if.address = a; rq0_if.burstcount = bc;
    end else begin
      rq1_if.read = 1'b1; rq1_if.address = a; rq1_if.burstcount = bc;
    end
    do begin
      @(negedge clock);
      n++;
    end while ((id ? rq1_if.waitrequest : rq0_if.waitrequest) && n < 200);
    if (n >= 200) check_eq("rq_accept_timeout", 1, 0);
    tick();
    if (!id) rq0_if.read = 1'b0;
    else     rq1_if.read = 1'b0;
  endtask

  // Present one slave beat for one cycle; the caller clears readdatavalid.
  task automatic beat(input bit v0, input bit v1, input logic [511:0] d);
    beat_q.push_back('{v0: v0, v1: v1, data: d});
    avm_if.readdatavalid = 1'b1;
    avm_if.readdata      = d;
    tick();
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (resetn) begin
      if (avm_if.read && !avm_if.waitrequest) begin
        accept_cnt++;
        if (cmd_q.size() == 0) check_eq("cmd_unexpected", 1, 0);
        else begin
          mon_c = cmd_q.pop_front();
          check_eq("cmd_addr", avm_if.address, mon_c.addr);
          check_eq("cmd_bc", avm_if.burstcount, mon_c.bc);
          check_eq("cmd_owner", {rq1_if.waitrequest, rq0_if.waitrequest},
                   mon_c.id ? 2'b01 : 2'b10);
        end
      end
      if (avm_if.readdatavalid) begin
        if (beat_q.size() == 0) check_eq("beat_unexpected", 1, 0);
        else begin
          mon_b = beat_q.pop_front();
          check_eq("beat_valid", {rq1_if.readdatavalid, rq0_if.readdatavalid},
                   {mon_b.v1, mon_b.v0});
          if (mon_b.v0 || mon_b.v1) begin
            check_eq("beat_data0", rq0_if.readdata, mon_b.data);
            check_eq("beat_data1", rq1_if.readdata, mon_b.data);
          end
        end
      end else begin
        check_eq("stray_valid", {rq1_if.readdatavalid, rq0_if.readdatavalid}, 2'b00);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned acc0;
    rq0_if.read = 1'b0; rq0_if.address = '0; rq0_if.burstcount = 1;
    rq1_if.read = 1'b0; rq1_if.address = '0; rq1_if.burstcount = 1;
    avm_if.waitrequest = 1'b0; avm_if.readdata = '0; avm_if.readdatavalid = 1'b0;

    // Reset state
    #12;
    check_eq("rst_avm_read", avm_if.read, 0);
    check_eq("rst_avm_addr", avm_if.address, 0);
    check_eq("rst_avm_bc", avm_if.burstcount, 0);
    check_eq("rst_rq_wait", {rq1_if.waitrequest, rq0_if.waitrequest}, 2'b11);
    check_eq("rst_rq_valid", {rq1_if.readdatavalid, rq0_if.readdatavalid}, 2'b00);
    check_eq("rst_err", err_unexpected, 0);
    check_eq("rst_avm_write", avm_write, 0);
    check_eq("rst_byteenable", avm_byteenable, {64{1'b1}});
    @(posedge clock); #1;
    resetn = 1'b1;

    // 1: rq0 alone, 16-beat burst, 1-cycle command latency
    cmd_q.push_back('{id: 1'b0, addr: 32'h1000, bc: 5'd16});
    rq0_if.read = 1'b1; rq0_if.address = 32'h1000; rq0_if.burstcount = 5'd16;
    @(negedge clock);
    check_eq("t1_no_early_read", avm_if.read, 0);
    tick();
    check_eq("t1_read_lat", avm_if.read, 1);
    check_eq("t1_addr", avm_if.address, 32'h1000);
    check_eq("t1_bc", avm_if.burstcount, 16);
    check_eq("t1_rq0_wait", rq0_if.waitrequest, 0);
    tick();
    rq0_if.read = 1'b0;
    check_eq("t1_read_drop", avm_if.read, 0);
    for (int k = 0; k < 16; k++) beat(1'b1, 1'b0, 512'(1 + 16 * k));
    avm_if.readdatavalid = 1'b0;
    tick();

    // 2: simultaneous request after reset -> rq0 then rq1, seamless beat switch
    do_reset();
    cmd_q.push_back('{id: 1'b0, addr: 32'h0,   bc: 5'd4});
    cmd_q.push_back('{id: 1'b1, addr: 32'h400, bc: 5'd3});
    fork
      rq_issue(1'b0, 32'h0, 5'd4);
      rq_issue(1'b1, 32'h400, 5'd3);
    join
    // rq0 alone, then a tie: rq1 must win since rq0 was granted last
    cmd_q.push_back('{id: 1'b0, addr: 32'h600, bc: 5'd1});
    rq_issue(1'b0, 32'h600, 5'd1);
    cmd_q.push_back('{id: 1'b1, addr: 32'hC00, bc: 5'd2});
    cmd_q.push_back('{id: 1'b0, addr: 32'h800, bc: 5'd2});
    fork
      rq_issue(1'b0, 32'h800, 5'd2);
      rq_issue(1'b1, 32'hC00, 5'd2);
    join
    for (int k = 0; k < 4; k++) beat(1'b1, 1'b0, 512'(32'hA000 + k));
    for (int k = 0; k < 3; k++) beat(1'b0, 1'b1, 512'(32'hB000 + k));
    beat(1'b1, 1'b0, 512'(32'hA100));
    for (int k = 0; k < 2; k++) beat(1'b0, 1'b1, 512'(32'hB100 + k));
    for (int k = 0; k < 2; k++) beat(1'b1, 1'b0, 512'(32'hA200 + k));
    avm_if.readdatavalid = 1'b0;
    tick();

    // 3: slave stalls 5 cycles in ISSUE
    avm_if.waitrequest = 1'b1;
    cmd_q.push_back('{id: 1'b0, addr: 32'h2000, bc: 5'd2});
    rq0_if.read = 1'b1; rq0_if.address = 32'h2000; rq0_if.burstcount = 5'd2;
    acc0 = accept_cnt;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_eq("t3_read_held", avm_if.read, 1);
      check_eq("t3_addr_held", avm_if.address, 32'h2000);
      check_eq("t3_bc_held", avm_if.burstcount, 2);
      check_eq("t3_rq0_wait", rq0_if.waitrequest, 1);
      tick();
    end
    avm_if.waitrequest = 1'b0;
    #1;
    check_eq("t3_rq0_accept", rq0_if.waitrequest, 0);
    tick();
    rq0_if.read = 1'b0;
    check_eq("t3_read_drop", avm_if.read, 0);
    tick();
    check_eq("t3_accept_once", accept_cnt - acc0, 1);
    for (int k = 0; k < 2; k++) beat(1'b1, 1'b0, 512'(32'hC000 + k));
    avm_if.readdatavalid = 1'b0;
    tick();

    // 4: tag FIFO full stalls the 9th command until one burst retires
    for (int i = 0; i < 8; i++) begin
      cmd_q.push_back('{id: 1'b0, addr: 32'(32'h100 * i), bc: 5'd1});
      rq_issue(1'b0, 32'(32'h100 * i), 5'd1);
    end
    cmd_q.push_back('{id: 1'b1, addr: 32'h9000, bc: 5'd1});
    rq1_if.read = 1'b1; rq1_if.address = 32'h9000; rq1_if.burstcount = 5'd1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("t4_full_wait", rq1_if.waitrequest, 1);
      check_eq("t4_full_noread", avm_if.read, 0);
    end
    beat(1'b1, 1'b0, 512'(32'hD000));
    avm_if.readdatavalid = 1'b0;
    check_eq("t4_pop_cycle", avm_if.read, 0);
    tick();
    check_eq("t4_granted", avm_if.read, 1);
    check_eq("t4_addr", avm_if.address, 32'h9000);
    tick();
    rq1_if.read = 1'b0;
    for (int k = 1; k < 8; k++) beat(1'b1, 1'b0, 512'(32'hD000 + k));
    beat(1'b0, 1'b1, 512'(32'hE000));
    avm_if.readdatavalid = 1'b0;
    tick();

    // 5: beat with nothing outstanding
    do_reset();
    check_eq("t5_err_clear", err_unexpected, 0);
    beat(1'b0, 1'b0, 512'(32'hDEAD));
    avm_if.readdatavalid = 1'b0;
    check_eq("t5_err_set", err_unexpected, 1);
    repeat (3) tick();
    check_eq("t5_err_sticky", err_unexpected, 1);
    resetn = 1'b0;
    #1;
    check_eq("t5_err_reset", err_unexpected, 0);
    do_reset();

    // 6: asynchronous reset in the middle of a 16-beat burst
    cmd_q.push_back('{id: 1'b0, addr: 32'h3000, bc: 5'd16});
    rq_issue(1'b0, 32'h3000, 5'd16);
    for (int k = 0; k < 3; k++) beat(1'b1, 1'b0, 512'(32'hF000 + k));
    avm_if.readdatavalid = 1'b0;
    #2;
    resetn = 1'b0;
    avm_if.readdatavalid = 1'b1;
    #1;
    check_eq("t6_avm_read", avm_if.read, 0);
    check_eq("t6_avm_addr", avm_if.address, 0);
    check_eq("t6_avm_bc", avm_if.burstcount, 0);
    check_eq("t6_rq_wait", {rq1_if.waitrequest, rq0_if.waitrequest}, 2'b11);
    check_eq("t6_rq_valid", {rq1_if.readdatavalid, rq0_if.readdatavalid}, 2'b00);
    check_eq("t6_err", err_unexpected, 0);
    avm_if.readdatavalid = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    cmd_q.push_back('{id: 1'b0, addr: 32'h4000, bc: 5'd2});
    cmd_q.push_back('{id: 1'b1, addr: 32'h5000, bc: 5'd2});
    fork
      rq_issue(1'b0, 32'h4000, 5'd2);
      rq_issue(1'b1, 32'h5000, 5'd2);
    join
    for (int k = 0; k < 2; k++) beat(1'b1, 1'b0, 512'(32'h4400 + k));
    for (int k = 0; k < 2; k++) beat(1'b0, 1'b1, 512'(32'h5500 + k));
    avm_if.readdatavalid = 1'b0;
    tick();
    check_eq("t6_no_err", err_unexpected, 0);

    check_eq("cmd_q_drained", cmd_q.size(), 0);
    check_eq("beat_q_drained", beat_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
